// File: rtl/uart_frame_packer_pkg.sv
// Shared types and constants for the UART frame packer: FSM state encoding,
// default header / channel bytes and a helper giving the framed byte count.
package uart_frame_packer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    H0,
    H1,
    CH,
    SQ,
    CN,
    RQ,
    WT,
    SH,
    SL,
    CS,
    DN
  } state_t;

  localparam logic [7:0] DEF_HDR0  = 8'hA5;
  localparam logic [7:0] DEF_HDR1  = 8'h5A;
  localparam logic [7:0] DEF_CH_ID = 8'h02;

  // Header, header, channel, sequence, count, two bytes per sample, checksum.
  function automatic int frame_bytes(input int nsamp);
    return 6 + 2 * nsamp;
  endfunction

endpackage

// File: rtl/uart_frame_packer.sv
// Drains NSAMP 14-bit samples from the channel FIFO and streams them to the
// byte transmitter as one resynchronisable frame:
//   HDR0 HDR1 CH_ID seq NSAMP {hi lo}*NSAMP CSUM
// CSUM is the modulo-256 sum of every byte from CH_ID to the last low byte.
module uart_frame_packer
  import uart_frame_packer_pkg::*;
#(
  parameter int         NSAMP = 64,
  parameter logic [7:0] HDR0  = DEF_HDR0,
  parameter logic [7:0] HDR1  = DEF_HDR1,
  parameter logic [7:0] CH_ID = DEF_CH_ID
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [13:0] fifo_q,
  input  logic        fifo_empty,
  output logic        fifo_rdreq,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  seq
);

  // The count byte is only 8 bits wide, so frames of 0 or >255 samples
  // cannot be described on the wire.
  generate
    if (NSAMP < 1 || NSAMP > 255) begin : g_bad_nsamp
      $error("uart_frame_packer: NSAMP must be within 1..255");
    end
  endgenerate

  localparam logic [7:0] NSAMP_BYTE = 8'(NSAMP);

  state_t      state;
  state_t      next_state;
  logic [7:0]  csum;
  logic [7:0]  cnt;
  logic [13:0] sample;
  logic        xfer;
  logic        last_sample;

  assign xfer        = tx_valid && tx_ready;
  assign last_sample = ((cnt + 8'd1) == NSAMP_BYTE);

  // State register; abort is folded into next_state so it wins everywhere.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: header bytes advance on transfer, sample fetch
  // stalls in RQ while the FIFO is empty.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = H0;
        H0:      if (xfer) next_state = H1;
        H1:      if (xfer) next_state = CH;
        CH:      if (xfer) next_state = SQ;
        SQ:      if (xfer) next_state = CN;
        CN:      if (xfer) next_state = RQ;
        RQ:      if (!fifo_empty) next_state = WT;
        WT:      next_state = SH;
        SH:      if (xfer) next_state = SL;
        SL:      if (xfer) next_state = last_sample ? CS : RQ;
        CS:      if (xfer) next_state = DN;
        DN:      next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs decoded from state; tx_data depends only on registered values,
  // so it holds steady while the transmitter back-pressures.
  always_comb begin
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    fifo_rdreq = 1'b0;
    busy       = (state != IDLE);
    frame_done = 1'b0;
    case (state)
      H0: begin
        tx_valid = 1'b1;
        tx_data  = HDR0;
      end
      H1: begin
        tx_valid = 1'b1;
        tx_data  = HDR1;
      end
      CH: begin
        tx_valid = 1'b1;
        tx_data  = CH_ID;
      end
      SQ: begin
        tx_valid = 1'b1;
        tx_data  = seq;
      end
      CN: begin
        tx_valid = 1'b1;
        tx_data  = NSAMP_BYTE;
      end
      RQ: fifo_rdreq = !fifo_empty && !abort;
      SH: begin
        tx_valid = 1'b1;
        tx_data  = {2'b00, sample[13:8]};
      end
      SL: begin
        tx_valid = 1'b1;
        tx_data  = sample[7:0];
      end
      CS: begin
        tx_valid = 1'b1;
        tx_data  = csum;
      end
      DN: frame_done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: checksum accumulation, sample capture, sample counting and
  // the per-frame sequence number; an aborted frame leaves seq untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq    <= 8'h00;
      csum   <= 8'h00;
      cnt    <= 8'h00;
      sample <= 14'h0000;
    end else if (!abort) begin
      case (state)
        IDLE: begin
          if (start) begin
            csum <= 8'h00;
            cnt  <= 8'h00;
          end
        end
        CH, SQ, CN, SH: begin
          if (xfer) csum <= csum + tx_data;
        end
        WT: sample <= fifo_q;
        SL: begin
          if (xfer) begin
            csum <= csum + tx_data;
            cnt  <= cnt + 8'd1;
          end
        end
        DN: seq <= seq + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed testbench for uart_frame_packer with NSAMP=2: FIFO and
// transmitter models, per-scenario tasks with inline expected values.
module tb_uart_frame_packer;
  import uart_frame_packer_pkg::*;

  localparam int NS = 2;
  localparam int FB = frame_bytes(NS);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [13:0] fifo_q = 14'h0000;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        frame_done;
  logic [7:0]  seq;

  int errors = 0;
  int checks = 0;

  logic [13:0] fifo_mem [0:1023];
  logic [9:0]  wr_ptr = 10'd0;
  logic [9:0]  rd_ptr = 10'd0;
  int          rd_count = 0;
  int          empty_reads = 0;

  logic [13:0] exp_q [$];
  logic [13:0] pend_q [$];
  logic [7:0]  exp_bytes [0:31];
  logic [7:0]  rx_bytes [0:31];
  int          rx_n;
  int          done_seen;
  int          hold_err;
  int          cyc_used;
  logic [7:0]  exp_seq;

  always #5 clk = ~clk;

  uart_frame_packer #(
    .NSAMP(NS),
    .HDR0 (8'hA5),
    .HDR1 (8'h5A),
    .CH_ID(8'h02)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .fifo_q    (fifo_q),
    .fifo_empty(fifo_empty),
    .fifo_rdreq(fifo_rdreq),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .frame_done(frame_done),
    .seq       (seq)
  );

  assign fifo_empty = (wr_ptr == rd_ptr);

  // Show-ahead-free FIFO read side: data appears the cycle after rdreq.
  always @(posedge clk) begin
    if (fifo_rdreq) begin
      rd_count <= rd_count + 1;
      if (wr_ptr != rd_ptr) begin
        fifo_q <= fifo_mem[rd_ptr];
        rd_ptr <= rd_ptr + 10'd1;
      end else begin
        empty_reads <= empty_reads + 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic push_sample(input logic [13:0] v);
    fifo_mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 10'd1;
    exp_q.push_back(v);
  endtask

  // Reference frame from the front of the expected-sample queue.
  task automatic build_expected(input logic [7:0] sq);
    logic [7:0]  sum;
    logic [13:0] smp;
    exp_bytes[0] = 8'hA5;
    exp_bytes[1] = 8'h5A;
    exp_bytes[2] = 8'h02;
    exp_bytes[3] = sq;
    exp_bytes[4] = 8'(NS);
    sum = 8'h02 + sq + 8'(NS);
    for (int i = 0; i < NS; i++) begin
      smp = exp_q.pop_front();
      exp_bytes[5 + 2 * i] = {2'b00, smp[13:8]};
      exp_bytes[6 + 2 * i] = smp[7:0];
      sum = sum + {2'b00, smp[13:8]} + smp[7:0];
    end
    exp_bytes[FB - 1] = sum;
  endtask

  function automatic int first_bad_byte();
    if (rx_n != FB) return FB;
    for (int i = 0; i < FB; i++) begin
      if (rx_bytes[i] !== exp_bytes[i]) return i;
    end
    return -1;
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    tx_ready = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Collects transferred bytes at negedges until frame_done or budget.
  task automatic capture_frame(input int ready_period, input int stall_push,
                               input int busy_start_at, input int max_cycles);
    logic       prev_hold;
    logic [7:0] prev_data;
    int         stall_cnt;
    rx_n = 0; done_seen = 0; hold_err = 0; cyc_used = 0;
    prev_hold = 1'b0; prev_data = 8'h00; stall_cnt = 0;
    for (int cyc = 0; cyc < max_cycles; cyc++) begin
      cyc_used = cyc + 1;
      if (prev_hold && (!tx_valid || tx_data !== prev_data)) hold_err++;
      if (frame_done) begin
        done_seen++;
        break;
      end
      start = (cyc == busy_start_at);
      if (stall_push > 0 && rx_n >= 5 && fifo_empty && pend_q.size() > 0) begin
        stall_cnt++;
        if (stall_cnt >= stall_push) begin
          push_sample(pend_q.pop_front());
          stall_cnt = 0;
        end
      end
      tx_ready = (ready_period <= 1) ? 1'b1 : ((cyc % ready_period) == ready_period - 1);
      if (tx_valid && tx_ready && rx_n < 32) begin
        rx_bytes[rx_n] = tx_data;
        rx_n++;
      end
      prev_hold = tx_valid && !tx_ready;
      prev_data = tx_data;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_valid, fifo_rdreq, busy, frame_done} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got valid/rdreq/busy/done=%b expected 0000",
               {tx_valid, fifo_rdreq, busy, frame_done});
    end
    checks++;
    if ({tx_data, seq} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL reset_data_seq: got tx_data=%h seq=%h expected 00 00", tx_data, seq);
    end
    rst_n = 1'b1;
    exp_seq = 8'h00;
  endtask

  task automatic test_basic_frame();
    logic [7:0] golden [0:9];
    int         bad;
    int         rd0;
    golden = '{8'hA5, 8'h5A, 8'h02, 8'h00, 8'h02, 8'h3A, 8'hBC, 8'h00, 8'h01, 8'hFB};
    rd0 = rd_count;
    push_sample(14'h3ABC);
    push_sample(14'h0001);
    pulse_start();
    capture_frame(1, 0, -1, 100);
    build_expected(exp_seq);
    bad = -1;
    if (rx_n != 10) bad = 10;
    else for (int i = 0; i < 10; i++) if (bad < 0 && rx_bytes[i] !== golden[i]) bad = i;
    checks++;
    if (bad != -1) begin
      errors++;
      $display("[TB] FAIL basic_bytes: idx=%0d got %h expected %h (got %0d bytes, expected 10)",
               bad, rx_bytes[bad], golden[bad % 10], rx_n);
    end
    checks++;
    if (done_seen != 1) begin
      errors++;
      $display("[TB] FAIL basic_done: got %0d frame_done pulses expected 1", done_seen);
    end
    @(negedge clk);
    checks++;
    if ({frame_done, busy} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL basic_done_width: got done/busy=%b expected 00", {frame_done, busy});
    end
    checks++;
    if (seq !== 8'h01) begin
      errors++;
      $display("[TB] FAIL basic_seq: got %h expected 01", seq);
    end
    checks++;
    if (rd_count - rd0 != 2 || empty_reads != 0) begin
      errors++;
      $display("[TB] FAIL basic_rdreq: got %0d reads (%0d empty) expected 2 (0 empty)",
               rd_count - rd0, empty_reads);
    end
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic test_ready_throttle();
    int bad;
    push_sample(14'h3ABC);
    push_sample(14'h0001);
    pulse_start();
    capture_frame(3, 0, -1, 200);
    build_expected(exp_seq);
    bad = first_bad_byte();
    checks++;
    if (bad != -1) begin
      errors++;
      $display("[TB] FAIL throttle_bytes: idx=%0d got %h expected %h (got %0d bytes)",
               bad, rx_bytes[bad], exp_bytes[bad], rx_n);
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("[TB] FAIL throttle_hold: got %0d unstable cycles expected 0", hold_err);
    end
    @(negedge clk);
    exp_seq = exp_seq + 8'd1;
    checks++;
    if (seq !== exp_seq) begin
      errors++;
      $display("[TB] FAIL throttle_seq: got %h expected %h", seq, exp_seq);
    end
  endtask

  task automatic test_fifo_stall();
    int bad;
    int rd0;
    rd0 = rd_count;
    pend_q.push_back(14'h1234);
    pend_q.push_back(14'h2FFF);
    pulse_start();
    capture_frame(1, 20, -1, 300);
    build_expected(exp_seq);
    bad = first_bad_byte();
    checks++;
    if (bad != -1) begin
      errors++;
      $display("[TB] FAIL stall_bytes: idx=%0d got %h expected %h (got %0d bytes)",
               bad, rx_bytes[bad], exp_bytes[bad], rx_n);
    end
    checks++;
    if (empty_reads != 0 || rd_count - rd0 != 2) begin
      errors++;
      $display("[TB] FAIL stall_rdreq: got %0d reads (%0d while empty) expected 2 (0)",
               rd_count - rd0, empty_reads);
    end
    checks++;
    if (cyc_used < 45) begin
      errors++;
      $display("[TB] FAIL stall_length: got frame in %0d cycles expected at least 45", cyc_used);
    end
    @(negedge clk);
    exp_seq = exp_seq + 8'd1;
    checks++;
    if (seq !== exp_seq) begin
      errors++;
      $display("[TB] FAIL stall_seq: got %h expected %h", seq, exp_seq);
    end
  endtask

  task automatic test_abort();
    int n;
    int rd0;
    int done_cnt;
    int bad;
    logic hit;
    rd0 = rd_count;
    push_sample(14'h0155);
    push_sample(14'h2AAA);
    pulse_start();
    n = 0;
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (n == 5 && tx_valid) begin
        abort = 1'b1;
        tx_ready = 1'b0;
        hit = 1'b1;
        break;
      end
      tx_ready = 1'b1;
      if (tx_valid) n++;
      @(negedge clk);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("[TB] FAIL abort_reach_sh: got %0d bytes without reaching sample high byte expected 5", n);
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({tx_valid, fifo_rdreq, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_outputs: got valid/rdreq/busy=%b expected 000",
               {tx_valid, fifo_rdreq, busy});
    end
    checks++;
    if (seq !== exp_seq) begin
      errors++;
      $display("[TB] FAIL abort_seq: got %h expected %h", seq, exp_seq);
    end
    done_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      if (frame_done) done_cnt++;
      @(negedge clk);
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got %0d frame_done cycles expected 0", done_cnt);
    end
    checks++;
    if (rd_count - rd0 != 1) begin
      errors++;
      $display("[TB] FAIL abort_reads: got %0d reads expected 1", rd_count - rd0);
    end
    void'(exp_q.pop_front());
    push_sample(14'h0777);
    pulse_start();
    capture_frame(1, 0, -1, 100);
    build_expected(exp_seq);
    bad = first_bad_byte();
    checks++;
    if (bad != -1) begin
      errors++;
      $display("[TB] FAIL abort_next_frame: idx=%0d got %h expected %h (got %0d bytes)",
               bad, rx_bytes[bad], exp_bytes[bad], rx_n);
    end
    @(negedge clk);
    exp_seq = exp_seq + 8'd1;
  endtask

  task automatic test_midframe_reset();
    int rd0;
    rd0 = rd_count;
    push_sample(14'h1111);
    push_sample(14'h2222);
    pulse_start();
    for (int c = 0; c < 3; c++) begin
      tx_ready = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    tx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_valid, fifo_rdreq, busy, frame_done} !== 4'b0000 || {tx_data, seq} !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL midreset_outputs: got flags=%b data=%h seq=%h expected 0000 00 00",
               {tx_valid, fifo_rdreq, busy, frame_done}, tx_data, seq);
    end
    checks++;
    if (rd_count - rd0 != 0) begin
      errors++;
      $display("[TB] FAIL midreset_reads: got %0d reads expected 0", rd_count - rd0);
    end
    rst_n = 1'b1;
    exp_seq = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int frames_bad;
    int seq_bad;
    int done_bad;
    int busy_bad;
    int rd0;
    frames_bad = 0; seq_bad = 0; done_bad = 0; busy_bad = 0;
    rd0 = rd_count;
    for (int f = 0; f < 257; f++) begin
      push_sample(14'(f * 37));
      push_sample(14'(16383 - f * 11));
      pulse_start();
      capture_frame(1, 0, (f == 5) ? 4 : -1, 100);
      build_expected(exp_seq);
      if (first_bad_byte() != -1) frames_bad++;
      if (rx_bytes[3] !== 8'(f)) seq_bad++;
      if (done_seen != 1) done_bad++;
      exp_seq = exp_seq + 8'd1;
      if (f == 5) begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          if (busy) busy_bad++;
        end
      end
    end
    checks++;
    if (frames_bad != 0) begin
      errors++;
      $display("[TB] FAIL b2b_frames: got %0d corrupted frames expected 0", frames_bad);
    end
    checks++;
    if (seq_bad != 0) begin
      errors++;
      $display("[TB] FAIL b2b_seq_bytes: got %0d wrong seq bytes expected 0", seq_bad);
    end
    checks++;
    if (done_bad != 0) begin
      errors++;
      $display("[TB] FAIL b2b_done: got %0d frames without frame_done expected 0", done_bad);
    end
    checks++;
    if (busy_bad != 0) begin
      errors++;
      $display("[TB] FAIL start_while_busy: got %0d busy cycles after frame expected 0", busy_bad);
    end
    checks++;
    if (rd_count - rd0 != 2 * 257 || empty_reads != 0) begin
      errors++;
      $display("[TB] FAIL b2b_reads: got %0d reads (%0d empty) expected %0d (0)",
               rd_count - rd0, empty_reads, 2 * 257);
    end
    @(negedge clk);
    checks++;
    if (seq !== 8'h01) begin
      errors++;
      $display("[TB] FAIL b2b_final_seq: got %h expected 01", seq);
    end
  endtask

  // Scenario sequence; every task leaves the DUT idle for the next one.
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tx_ready = 1'b0;
    exp_seq = 8'h00;
    test_reset();
    test_basic_frame();
    test_ready_throttle();
    test_fifo_stall();
    test_abort();
    test_midframe_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
